// File: rtl/pulse_stretcher.sv
// Stretches short event pulses into output pulses with a guaranteed minimum ON and OFF time.
// One event can be queued while a pulse runs; any further event is dropped and flagged in overrun_o.
module pulse_stretcher #(
    parameter int unsigned clk_freq  = 12_000_000,
    parameter int unsigned on_freq   = 20,
    parameter int unsigned off_freq  = 20,
    parameter bit          retrigger = 1'b1
) (
    input  logic clk,
    input  logic areset_n,
    input  logic event_i,
    input  logic clr_i,
    output logic drive_o,
    output logic busy_o,
    output logic overrun_o
);

    localparam int unsigned on_limit  = clk_freq / on_freq;
    localparam int unsigned off_limit = clk_freq / off_freq;
    localparam int unsigned max_limit = (on_limit > off_limit) ? on_limit : off_limit;
    localparam int unsigned cnt_w     = $clog2(max_limit + 1);

    localparam logic [cnt_w-1:0] on_last  = cnt_w'(on_limit - 1);
    localparam logic [cnt_w-1:0] off_last = cnt_w'(off_limit - 1);

    if (on_limit < 1) begin : g_on_limit_check
        $error("pulse_stretcher: on_limit must be at least 1");
    end
    if (off_limit < 1) begin : g_off_limit_check
        $error("pulse_stretcher: off_limit must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff
    } state_e;

    state_e             state_q, state_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic               event_q;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               drive_q, busy_q;
    logic               ev_rise;
    logic               lost;

    assign ev_rise = event_i & ~event_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        lost      = 1'b0;

        case (state_q)
            StIdle: begin
                if (ev_rise) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end
            end

            StOn: begin
                // A restart beats the end-of-ON transition, even on the last ON cycle.
                if (ev_rise && retrigger) begin
                    cnt_d = '0;
                end else begin
                    if (cnt_q == on_last) begin
                        state_d = StOff;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (ev_rise) begin
                        if (pending_q) begin
                            lost = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                end
            end

            StOff: begin
                if (cnt_q == off_last) begin
                    cnt_d = '0;
                    if (pending_q) begin
                        state_d   = StOn;
                        pending_d = 1'b0;
                        lost      = ev_rise;
                    end else if (ev_rise) begin
                        // Consumed directly: the next pulse starts without going through pending.
                        state_d = StOn;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (ev_rise) begin
                        if (pending_q) begin
                            lost = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d   = StIdle;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    // Setting wins over clearing so a loss in the clear cycle is never hidden.
    always_comb begin
        overrun_d = overrun_q;
        if (lost) begin
            overrun_d = 1'b1;
        end else if (clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            event_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            event_q   <= event_i;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            drive_q   <= (state_d == StOn);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign drive_o   = drive_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: dut_a retriggers, dut_b queues; on_limit=10, off_limit=5.
// Run-length vectors give the expected outputs after each clock edge.
module tb_pulse_stretcher;

    logic clk;
    logic areset_n;
    logic ev_a, clr_a, drive_a, busy_a, ovr_a;
    logic ev_b, clr_b, drive_b, busy_b, ovr_b;

    int checks;
    int failures;

    typedef struct {
        bit sel;   // 0 = dut_a (retrigger), 1 = dut_b (queue)
        bit ev;
        bit clr;
        int n;
        bit drive;
        bit busy;
        bit ovr;
    } vec_t;

    vec_t vecs[$];

    pulse_stretcher #(
        .clk_freq (100),
        .on_freq  (10),
        .off_freq (20),
        .retrigger(1'b1)
    ) dut_a (
        .clk      (clk),
        .areset_n (areset_n),
        .event_i  (ev_a),
        .clr_i    (clr_a),
        .drive_o  (drive_a),
        .busy_o   (busy_a),
        .overrun_o(ovr_a)
    );

    pulse_stretcher #(
        .clk_freq (100),
        .on_freq  (10),
        .off_freq (20),
        .retrigger(1'b0)
    ) dut_b (
        .clk      (clk),
        .areset_n (areset_n),
        .event_i  (ev_b),
        .clr_i    (clr_b),
        .drive_o  (drive_b),
        .busy_o   (busy_b),
        .overrun_o(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit sel, input bit d, input bit b,
                            input bit o);
        if (sel) begin
            chk({tag, " drive_b"}, drive_b, d);
            chk({tag, " busy_b"}, busy_b, b);
            chk({tag, " overrun_b"}, ovr_b, o);
        end else begin
            chk({tag, " drive_a"}, drive_a, d);
            chk({tag, " busy_a"}, busy_a, b);
            chk({tag, " overrun_a"}, ovr_a, o);
        end
    endtask

    function automatic void add(bit sel, bit ev, bit clr, int n, bit d, bit b, bit o);
        vec_t v;
        v.sel = sel; v.ev = ev; v.clr = clr; v.n = n;
        v.drive = d; v.busy = b; v.ovr = o;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset state / first edge with event_i already high at release
        add(0, 1, 0, 10, 1, 1, 0);
        add(0, 1, 0,  5, 0, 1, 0);
        add(0, 0, 0,  3, 0, 0, 0);
        // Retrigger: second edge on ON cycle 6 -> 16 high
        add(0, 1, 0,  1, 1, 1, 0);
        add(0, 0, 0,  5, 1, 1, 0);
        add(0, 1, 0,  1, 1, 1, 0);
        add(0, 0, 0,  9, 1, 1, 0);
        add(0, 0, 0,  5, 0, 1, 0);
        add(0, 0, 0,  2, 0, 0, 0);
        // Queue: edges at t=0 and t=3
        add(1, 1, 0,  1, 1, 1, 0);
        add(1, 0, 0,  2, 1, 1, 0);
        add(1, 1, 0,  1, 1, 1, 0);
        add(1, 0, 0,  6, 1, 1, 0);
        add(1, 0, 0,  5, 0, 1, 0);
        add(1, 0, 0, 10, 1, 1, 0);
        add(1, 0, 0,  5, 0, 1, 0);
        add(1, 0, 0,  2, 0, 0, 0);
        // Overrun: edges at t=0, t=11, t=13
        add(1, 1, 0,  1, 1, 1, 0);
        add(1, 0, 0,  9, 1, 1, 0);
        add(1, 0, 0,  1, 0, 1, 0);
        add(1, 1, 0,  1, 0, 1, 0);
        add(1, 0, 0,  1, 0, 1, 0);
        add(1, 1, 0,  1, 0, 1, 1);
        add(1, 0, 0,  1, 0, 1, 1);
        add(1, 0, 0, 10, 1, 1, 1);
        add(1, 0, 0,  5, 0, 1, 1);
        add(1, 0, 0,  2, 0, 0, 1);
        add(1, 0, 1,  1, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 0);
        // clr_i coinciding with a lost edge keeps overrun set
        add(1, 1, 0,  1, 1, 1, 0);
        add(1, 0, 0,  1, 1, 1, 0);
        add(1, 1, 0,  1, 1, 1, 0);
        add(1, 0, 0,  1, 1, 1, 0);
        add(1, 1, 1,  1, 1, 1, 1);
        add(1, 0, 0,  5, 1, 1, 1);
        add(1, 0, 0,  5, 0, 1, 1);
        add(1, 0, 0, 10, 1, 1, 1);
        add(1, 0, 0,  5, 0, 1, 1);
        add(1, 0, 0,  2, 0, 0, 1);
        add(1, 0, 1,  1, 0, 0, 0);
        // Edge exactly on the last OFF cycle is consumed, gap exactly 5
        add(0, 1, 0,  1, 1, 1, 0);
        add(0, 0, 0,  9, 1, 1, 0);
        add(0, 0, 0,  5, 0, 1, 0);
        add(0, 1, 0,  1, 1, 1, 0);
        add(0, 0, 0,  9, 1, 1, 0);
        add(0, 0, 0,  5, 0, 1, 0);
        add(0, 0, 0,  2, 0, 0, 0);

        areset_n = 1'b0;
        ev_a = 1'b1; clr_a = 1'b0;
        ev_b = 1'b0; clr_b = 1'b0;
        #2;
        chk_outs("reset", 0, 0, 0, 0);
        repeat (2) step();
        chk_outs("reset_clocked", 0, 0, 0, 0);
        areset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].sel) begin
                ev_b = vecs[i].ev; clr_b = vecs[i].clr;
            end else begin
                ev_a = vecs[i].ev; clr_a = vecs[i].clr;
            end
            for (int k = 0; k < vecs[i].n; k++) begin
                step();
                chk_outs($sformatf("vec%0d.%0d", i, k), vecs[i].sel, vecs[i].drive,
                         vecs[i].busy, vecs[i].ovr);
            end
        end
        ev_a = 1'b0; clr_a = 1'b0;
        ev_b = 1'b0; clr_b = 1'b0;

        // Mid-pulse async reset with pending and overrun set
        ev_b = 1'b1; step(); chk_outs("mid_t0", 1, 1, 1, 0);
        ev_b = 1'b0; step();
        ev_b = 1'b1; step();
        ev_b = 1'b0; step();
        ev_b = 1'b1; step(); chk_outs("mid_lost", 1, 1, 1, 1);
        ev_b = 1'b0;
        #2;
        areset_n = 1'b0;
        #1;
        chk_outs("mid_async", 1, 0, 0, 0);
        repeat (2) step();
        areset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk_outs($sformatf("post_reset.%0d", k), 1, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart of the input debouncer. It turns short internal event pulses into clean, human- or relay-visible output pulses on a physical pin (LED, buzzer, relay driver).
- Guarantees a minimum ON time and a minimum OFF (recovery) time.
- Buffers one pending event and flags overruns.
- Sits between core logic and the output pad; the output needs no further filtering.

Parameters:
- clk_freq, 12_000_000: clock frequency in Hz.
- on_freq, 20: on_limit = clk_freq/on_freq cycles of guaranteed ON time (default 50 ms).
- off_freq, 20: off_limit = clk_freq/off_freq cycles of guaranteed OFF time after each pulse.
- retrigger, 1: 1 = an edge during ON restarts the ON timer; 0 = an edge during ON is queued as pending.

Ports:
- clk  input  1  system clock.
- areset_n  input  1  asynchronous active-low reset.
- event_i  input  1  request; a rising edge (event_i=1 while previous sample 0) is one event; synchronous to clk.
- clr_i  input  1  clears overrun_o.
- drive_o  output  1  stretched output pulse, registered.
- busy_o  output  1  high when state is not IDLE, registered.
- overrun_o  output  1  sticky flag: an event was lost.

Behaviour:
- Reset (async, areset_n=0): state=IDLE, counter=0, event_q=0, pending=0; drive_o=0, busy_o=0, overrun_o=0.
- Edge detect: edge = event_i & ~event_q; event_q <= event_i every cycle.
  - event_q resets to 0, so event_i already high at reset release is an edge on the first clock.
- Counter width: $clog2(max(on_limit, off_limit)+1).
- Elaboration check: on_limit >= 1 and off_limit >= 1.
- States: IDLE, ON, OFF. All outputs are registered and change on the clock edge that changes state.
- IDLE:
  - drive_o=0.
  - On edge: go to ON, cnt=0, drive_o=1 on the next cycle. Latency is 1 clock from the sampled edge.
- ON:
  - drive_o=1; cnt increments each cycle.
  - When cnt==on_limit-1: go to OFF, cnt=0. A single edge therefore yields exactly on_limit cycles of drive_o=1.
  - Edge during ON with retrigger=1: cnt<=0 (ON extends; on_limit cycles counted from the edge). This applies on the last ON cycle too: the restart wins and there is no transition.
  - Edge during ON with retrigger=0: set pending.
- OFF:
  - drive_o=0; cnt increments.
  - When cnt==off_limit-1: if pending (or an edge arrives in this same cycle), go to ON, cnt=0, clear pending. Otherwise go to IDLE.
  - Edge during OFF: set pending.
- Pending holds one event only.
  - An edge arriving while pending=1, or while pending is being set in the same cycle, is lost and sets overrun_o.
  - An edge in the final OFF cycle with pending=0 is consumed directly (ON next cycle), not lost.
- overrun_o:
  - Set has priority over clr_i in the same cycle.
  - Otherwise clr_i=1 clears it on the next clock.
  - clr_i has no effect on state or pending.
- busy_o=1 in ON and OFF, 0 in IDLE.
- Back-to-back pulses always have drive_o low for at least off_limit cycles.
- Level high held on event_i counts as one event only; holding it does not extend ON.
- Reset asserted mid-pulse: drive_o drops immediately (async); pending and overrun are discarded.

Test Plan:
Bench parameters: clk_freq=100, on_freq=10, off_freq=20, giving on_limit=10 and off_limit=5.

1. Reset: areset_n low with event_i=1 -> drive_o=busy_o=overrun_o=0. After release, drive_o=1 one clock after the first edge; high exactly 10 cycles; then busy_o high 5 more cycles; then IDLE.
2. Retrigger=1: edge at t=0, second edge at ON cycle 6 -> drive_o high 16 cycles total, then 5 OFF cycles, then IDLE; overrun_o=0.
3. Retrigger=0: edges at t=0 and t=3 -> 10 high, 5 low, 10 high, 5 low, IDLE; overrun_o=0.
4. Overrun: edges at t=0, t=11 (OFF), and t=13 (OFF) -> one queued pulse is produced, overrun_o=1. clr_i pulse -> overrun_o=0 next clock. clr_i in the same cycle as a lost edge -> overrun_o stays 1.
5. Boundary: single edge exactly on the last OFF cycle -> drive_o rises on the next cycle with low gap exactly 5; overrun_o=0.
6. Mid-pulse reset: areset_n low at ON cycle 4 with pending=1 -> drive_o=0 immediately. After release with event_i=0, the block stays IDLE and no queued pulse appears.
